usb_rx_decode: RTL and testbench

Receive-side line decoder for the USB bulk-transfer path. It sits directly downstream of the receive clock divider and consumes its one-cycle sample strobe. It synchronizes the raw D+/D- pins, samples them on each strobe, and NRZI-decodes the line. It also removes stuffed bits and flags SE0 end-of-packet, handing a clean bit stream with a valid pulse to the RX shift register and packet FSM.

---
 rtl/usb_rx_decode_pkg.sv | 17 +
 rtl/usb_rx_decode_if.sv | 37 +++
 rtl/usb_rx_decode_sync_2ff.sv | 30 +++
 rtl/usb_rx_decode.sv | 133 +++++++++++++
 tb/tb_usb_rx_decode.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/usb_rx_decode_pkg.sv
// usb_rx_pkg: shared types and constants for the USB receive line decoder.
//   state_t     - decoder state (ACTIVE, SE0_1, EOP_WAIT)
//   SYNC_STAGES - flop depth of each pin synchronizer
//   IDLE_DP/DM  - idle J line levels, used as synchronizer reset values
package usb_rx_pkg;

    typedef enum logic [1:0] {
        ACTIVE   = 2'd0,
        SE0_1    = 2'd1,
        EOP_WAIT = 2'd2
    } state_t;

    localparam int   SYNC_STAGES = 2;
    localparam logic IDLE_DP     = 1'b1;
    localparam logic IDLE_DM     = 1'b0;

endpackage

// File: rtl/usb_rx_decode_if.sv
// usb_rx_decode_if: line-side inputs and decoded-bit outputs of usb_rx_decode.
//   d_plus, d_minus : raw pins (asynchronous to clk)
//   shift_strobe    : one-clk line-sample strobe from the clock divider
//   d_orig          : last decoded data bit
//   bit_valid       : one-clk pulse, d_orig holds a new data bit
//   stuff_err       : one-clk pulse, bit after the ones run decoded as 1
//   eop             : one-clk pulse, SE0 end-of-packet seen
//   d_edge          : one-clk pulse on any synchronized D+ transition
//   dbg_state       : current decoder state, for observation only
// There is no backpressure: the strobe is a plain valid with no ready, and
// every output pulse is a valid lasting exactly one clk that must be
// consumed in that cycle.
interface usb_rx_decode_if;
    import usb_rx_pkg::*;

    logic   d_plus;
    logic   d_minus;
    logic   shift_strobe;
    logic   d_orig;
    logic   bit_valid;
    logic   stuff_err;
    logic   eop;
    logic   d_edge;
    state_t dbg_state;

    // master: line / clock-divider side; slave: the decoder.
    modport master (
        output d_plus, d_minus, shift_strobe,
        input  d_orig, bit_valid, stuff_err, eop, d_edge, dbg_state
    );

    modport slave (
        input  d_plus, d_minus, shift_strobe,
        output d_orig, bit_valid, stuff_err, eop, d_edge, dbg_state
    );

endinterface

// File: rtl/usb_rx_decode_sync_2ff.sv
// sync_2ff: multi-flop synchronizer for one asynchronous pin.
//   clk, n_rst : clock and asynchronous active-low reset
//   i_d        : asynchronous input
//   o_q        : synchronized output, SYNC_STAGES clks behind i_d
// RST_VAL sets the level the chain holds in reset, so the decoder sees a
// clean idle line straight out of reset.
module sync_2ff
    import usb_rx_pkg::*;
#(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic n_rst,
    input  logic i_d,
    output logic o_q
);

    logic [SYNC_STAGES-1:0] r_sync;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_sync <= {SYNC_STAGES{RST_VAL}};
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_d};
        end
    end

    assign o_q = r_sync[SYNC_STAGES-1];

endmodule

// File: rtl/usb_rx_decode.sv
// usb_rx_decode: USB receive line decoder.
//   clk, n_rst : clock and asynchronous active-low reset
//   bus        : usb_rx_decode_if.slave (pins, strobe, decoded outputs)
// Synchronizes D+/D-, samples them on each shift_strobe, NRZI-decodes,
// drops stuff bits after STUFF_LIMIT consecutive ones, flags a stuff error
// when that bit is a 1, and reports SE0-SE0 as end of packet. A lone SE0
// sample is treated as a glitch. d_edge runs every clk for strobe alignment.
module usb_rx_decode
    import usb_rx_pkg::*;
#(
    parameter int STUFF_LIMIT = 6
) (
    input  logic            clk,
    input  logic            n_rst,
    usb_rx_decode_if.slave  bus
);

    localparam logic [2:0] LIMIT = 3'(STUFF_LIMIT);

    logic       w_dp_s;
    logic       w_dm_s;
    logic       w_se0;
    logic       w_is_j;
    logic       w_bit;
    logic       w_do_decode;

    logic       r_dp_prev_edge;
    logic       r_d_edge;
    state_t     r_state;
    logic       r_prev_dp;
    logic [2:0] r_ones_cnt;
    logic       r_d_orig;
    logic       r_bit_valid;
    logic       r_stuff_err;
    logic       r_eop;

    sync_2ff #(.RST_VAL(IDLE_DP)) u_sync_dp (
        .clk   (clk),
        .n_rst (n_rst),
        .i_d   (bus.d_plus),
        .o_q   (w_dp_s)
    );

    sync_2ff #(.RST_VAL(IDLE_DM)) u_sync_dm (
        .clk   (clk),
        .n_rst (n_rst),
        .i_d   (bus.d_minus),
        .o_q   (w_dm_s)
    );

    assign w_se0  = !w_dp_s && !w_dm_s;
    assign w_is_j = w_dp_s && !w_dm_s;
    // NRZI: no transition on the line means a 1.
    assign w_bit  = (w_dp_s == r_prev_dp);
    // A non-SE0 sample in SE0_1 is decoded just like one in ACTIVE.
    assign w_do_decode = bus.shift_strobe && !w_se0 &&
                         ((r_state == ACTIVE) || (r_state == SE0_1));

    // Edge detector, free-running and independent of the strobe.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_dp_prev_edge <= IDLE_DP;
            r_d_edge       <= 1'b0;
        end else begin
            r_dp_prev_edge <= w_dp_s;
            r_d_edge       <= w_dp_s ^ r_dp_prev_edge;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state     <= ACTIVE;
            r_prev_dp   <= 1'b1;
            r_ones_cnt  <= 3'd0;
            r_d_orig    <= 1'b1;
            r_bit_valid <= 1'b0;
            r_stuff_err <= 1'b0;
            r_eop       <= 1'b0;
        end else begin
            r_bit_valid <= 1'b0;
            r_stuff_err <= 1'b0;
            r_eop       <= 1'b0;

            if (w_do_decode) begin
                r_prev_dp <= w_dp_s;
                if (r_ones_cnt == LIMIT) begin
                    // Bit after a full run of ones: a 0 is the stuff bit
                    // and is dropped silently; a 1 is a stuffing violation.
                    r_ones_cnt  <= 3'd0;
                    r_stuff_err <= w_bit;
                end else begin
                    r_d_orig    <= w_bit;
                    r_bit_valid <= 1'b1;
                    r_ones_cnt  <= w_bit ? (r_ones_cnt + 3'd1) : 3'd0;
                end
            end

            if (bus.shift_strobe) begin
                case (r_state)
                    ACTIVE: begin
                        if (w_se0) r_state <= SE0_1;
                    end
                    SE0_1: begin
                        if (w_se0) begin
                            r_eop   <= 1'b1;
                            r_state <= EOP_WAIT;
                        end else begin
                            r_state <= ACTIVE;
                        end
                    end
                    EOP_WAIT: begin
                        // Return to idle decode only once the bus is back at J.
                        if (w_is_j) begin
                            r_prev_dp  <= 1'b1;
                            r_ones_cnt <= 3'd0;
                            r_d_orig   <= 1'b1;
                            r_state    <= ACTIVE;
                        end
                    end
                    default: r_state <= ACTIVE;
                endcase
            end
        end
    end

    assign bus.d_orig    = r_d_orig;
    assign bus.bit_valid = r_bit_valid;
    assign bus.stuff_err = r_stuff_err;
    assign bus.eop       = r_eop;
    assign bus.d_edge    = r_d_edge;
    assign bus.dbg_state = r_state;

endmodule

// File: tb/tb_usb_rx_decode.sv
module tb_usb_rx_decode;
  import usb_rx_pkg::*;

  logic clk;
  logic n_rst;

  usb_rx_decode_if bus ();

  usb_rx_decode #(.STUFF_LIMIT(6)) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  int tests_run = 0;
  int tests_failed = 0;

  // Values sampled around the most recent strobe.
  logic s_edge;
  logic s_bv, s_d, s_se, s_eop;
  logic n_bv, n_se, n_eop;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checks ----------------
  task automatic check(input string tag, input logic obs, input logic exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check_st(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(negedge clk);
    n_rst = 1'b0;
    bus.d_plus = 1'b1;
    bus.d_minus = 1'b0;
    bus.shift_strobe = 1'b0;
    repeat (3) @(negedge clk);
    n_rst = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  // One 8-clk bit period: set the pins, let them pass the synchronizer,
  // strobe once, then sample the strobe results and the clk after.
  task automatic sym(input logic dp, input logic dm);
    @(negedge clk);
    bus.d_plus = dp;
    bus.d_minus = dm;
    repeat (2) @(negedge clk);
    @(negedge clk);
    s_edge = bus.d_edge;
    bus.shift_strobe = 1'b1;
    @(negedge clk);
    bus.shift_strobe = 1'b0;
    s_bv = bus.bit_valid;
    s_d = bus.d_orig;
    s_se = bus.stuff_err;
    s_eop = bus.eop;
    @(negedge clk);
    n_bv = bus.bit_valid;
    n_se = bus.stuff_err;
    n_eop = bus.eop;
    repeat (2) @(negedge clk);
  endtask

  task automatic sym_j();
    sym(1'b1, 1'b0);
  endtask

  task automatic sym_k();
    sym(1'b0, 1'b1);
  endtask

  task automatic sym_se0();
    sym(1'b0, 1'b0);
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    logic [7:0] sync_exp;
    sync_exp = 8'b1000_0000;  // bit i = decoded bit of symbol i

    n_rst = 1'b0;
    bus.d_plus = 1'b1;
    bus.d_minus = 1'b0;
    bus.shift_strobe = 1'b0;
    repeat (2) @(negedge clk);

    // Reset values while held in reset.
    check("rst_d_orig", bus.d_orig, 1'b1);
    check("rst_bit_valid", bus.bit_valid, 1'b0);
    check("rst_stuff_err", bus.stuff_err, 1'b0);
    check("rst_eop", bus.eop, 1'b0);
    check("rst_d_edge", bus.d_edge, 1'b0);
    check_st("rst_state", bus.dbg_state, ACTIVE);

    // Idle J: each strobe decodes as 1 until the ones run is full.
    do_reset();
    for (int i = 0; i < 6; i++) begin
      sym_j();
      check($sformatf("idle_bv_%0d", i), s_bv, 1'b1);
      check($sformatf("idle_d_%0d", i), s_d, 1'b1);
      check($sformatf("idle_se_%0d", i), s_se, 1'b0);
      check($sformatf("idle_edge_%0d", i), s_edge, 1'b0);
    end
    check("idle_bv_one_clk", n_bv, 1'b0);

    // SYNC KJKJKJKK -> 0000000 1.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      if (i == 7 || (i % 2) == 0) sym_k();
      else sym_j();
      check($sformatf("sync_bv_%0d", i), s_bv, 1'b1);
      check($sformatf("sync_d_%0d", i), s_d, sync_exp[i]);
      check($sformatf("sync_bv_next_%0d", i), n_bv, 1'b0);
      if (i < 7) check($sformatf("sync_edge_%0d", i), s_edge, 1'b1);
      else check("sync_edge_kk", s_edge, 1'b0);
    end

    // Six ones, then a stuff toggle that must be dropped, then a normal 0.
    do_reset();
    for (int i = 0; i < 6; i++) begin
      sym_j();
      check($sformatf("stuff_bv_%0d", i), s_bv, 1'b1);
      check($sformatf("stuff_d_%0d", i), s_d, 1'b1);
    end
    sym_k();
    check("stuff_drop_bv", s_bv, 1'b0);
    check("stuff_drop_se", s_se, 1'b0);
    check("stuff_drop_d_hold", s_d, 1'b1);
    sym_k();
    check("after_stuff_bv", s_bv, 1'b1);
    check("after_stuff_d", s_d, 1'b1);
    sym_j();
    check("after_stuff_zero_bv", s_bv, 1'b1);
    check("after_stuff_zero_d", s_d, 1'b0);

    // Seven ones with no toggle -> stuff_err once, no bit.
    do_reset();
    for (int i = 0; i < 6; i++) sym_j();
    check("pre_err_bv", s_bv, 1'b1);
    sym_j();
    check("stuff_err_pulse", s_se, 1'b1);
    check("stuff_err_no_bv", s_bv, 1'b0);
    check("stuff_err_one_clk", n_se, 1'b0);
    sym_j();
    check("post_err_bv", s_bv, 1'b1);
    check("post_err_d", s_d, 1'b1);
    check("post_err_se", s_se, 1'b0);

    // EOP: J, K, SE0, SE0, J (no bit), J (bit 1).
    do_reset();
    sym_j();
    sym_k();
    check("eop_pre_d", s_d, 1'b0);
    sym_se0();
    check("eop_se0a_bv", s_bv, 1'b0);
    check("eop_se0a_eop", s_eop, 1'b0);
    check_st("eop_se0a_state", bus.dbg_state, SE0_1);
    sym_se0();
    check("eop_pulse", s_eop, 1'b1);
    check("eop_no_bv", s_bv, 1'b0);
    check("eop_one_clk", n_eop, 1'b0);
    check_st("eop_wait_state", bus.dbg_state, EOP_WAIT);
    sym_j();
    check("eop_j1_bv", s_bv, 1'b0);
    check("eop_j1_d", s_d, 1'b1);
    check_st("eop_j1_state", bus.dbg_state, ACTIVE);
    sym_j();
    check("eop_j2_bv", s_bv, 1'b1);
    check("eop_j2_d", s_d, 1'b1);

    // Glitch: single SE0 between K samples; prev_dp is held across it.
    do_reset();
    sym_j();
    sym_k();
    sym_se0();
    check("glitch_se0_bv", s_bv, 1'b0);
    sym_k();
    check("glitch_eop", s_eop, 1'b0);
    check("glitch_bv", s_bv, 1'b1);
    check("glitch_d", s_d, 1'b1);
    check_st("glitch_state", bus.dbg_state, ACTIVE);
    sym_j();
    check("glitch_next_d", s_d, 1'b0);

    // Reset mid-packet: applied right as a bit_valid is high with d_orig = 0.
    do_reset();
    sym_j();
    @(negedge clk);
    bus.d_plus = 1'b0;
    bus.d_minus = 1'b1;
    repeat (3) @(negedge clk);
    bus.shift_strobe = 1'b1;
    @(negedge clk);
    bus.shift_strobe = 1'b0;
    check("mid_pre_bv", bus.bit_valid, 1'b1);
    check("mid_pre_d", bus.d_orig, 1'b0);
    #1;
    n_rst = 1'b0;
    #1;
    check("mid_rst_bv", bus.bit_valid, 1'b0);
    check("mid_rst_d", bus.d_orig, 1'b1);
    check_st("mid_rst_state", bus.dbg_state, ACTIVE);
    repeat (2) @(negedge clk);
    check("mid_rst_eop", bus.eop, 1'b0);
    n_rst = 1'b1;

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
